// File: rtl/ars_pdouble_gen.sv
// +----------------------------------------------------------------------------+
// | Module  : ars_pdouble_gen                                                   |
// | Brief   : GF(2^M) projective point doubling (Lopez-Dahab style X/Z only).   |
// |           X2 = X1^4 + b*Z1^4, Z2 = X1^2*Z1^2. Macro ARS_BCOEF_EN adds b_in. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module ars_pdouble_gen #(
  parameter int          M    = 233,
  parameter logic [M-1:0] POLY = M'(1) | (M'(1) << 74),
  parameter int          D    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] x_in,
  input  logic [M-1:0] z_in,
`ifdef ARS_BCOEF_EN
  input  logic [M-1:0] b_in,
`endif
  output logic         busy,
  output logic         done,
  output logic [M-1:0] x_out,
  output logic [M-1:0] z_out
);

  localparam int K  = (M + D - 1) / D;
  localparam int KD = K * D;
  localparam int CW = $clog2(K + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQ1  = 3'd1,
    S_MUL  = 3'd2,
    S_SQ2  = 3'd3,
    S_MULB = 3'd4,
    S_ADD  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   a_q, a_d;
  logic [M-1:0]   t_q, t_d;
  logic [M-1:0]   acc_q, acc_d;
  logic [KD-1:0]  sh_q, sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   xo_q, xo_d;
  logic [M-1:0]   zo_q, zo_d;
  logic [M-1:0]   mul_a;
`ifdef ARS_BCOEF_EN
  logic [M-1:0]   b_q, b_d;
`endif

  function automatic logic [M-1:0] gf_mulx(input logic [M-1:0] v);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
  endfunction

  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] v);
    logic [2*M-2:0] w;
    w = '0;
    for (int i = 0; i < M; i++) w[2*i] = v[i];
    // Fold from the top so bits pushed down by POLY are reduced in turn.
    for (int i = 2*M-2; i >= M; i--) begin
      if (w[i]) w[i-M +: M] = w[i-M +: M] ^ POLY;
    end
    return w[M-1:0];
  endfunction

  // One MSB-first digit step: acc*x^D + a*digit, reduced bit by bit (Horner).
  function automatic logic [M-1:0] gf_mac_digit(input logic [M-1:0] acc,
                                                 input logic [M-1:0] a,
                                                 input logic [D-1:0] dg);
    logic [M-1:0] r;
    r = acc;
    for (int i = D-1; i >= 0; i--) r = gf_mulx(r) ^ (dg[i] ? a : '0);
    return r;
  endfunction

`ifdef ARS_BCOEF_EN
  assign mul_a = (state_q == S_MULB) ? b_q : a_q;
`else
  assign mul_a = a_q;
`endif

  assign busy  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done  = (state_q == S_DONE);
  assign x_out = xo_q;
  assign z_out = zo_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    t_d     = t_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    xo_d    = xo_q;
    zo_d    = zo_q;
`ifdef ARS_BCOEF_EN
    b_d     = b_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = x_in;
          t_d     = z_in;
`ifdef ARS_BCOEF_EN
          b_d     = b_in;
`endif
          state_d = S_SQ1;
        end
      end
      S_SQ1: begin
        a_d     = gf_sq(a_q);
        t_d     = gf_sq(t_q);
        cnt_d   = '0;
        state_d = S_MUL;
      end
      S_MUL, S_MULB: begin
        // Count 0 loads the multiplier, counts 1..K consume one digit each.
        if (cnt_q == '0) begin
          acc_d          = '0;
          sh_d           = '0;
          sh_d[M-1:0]    = t_q;
          cnt_d          = CW'(1);
        end else begin
          acc_d = gf_mac_digit(acc_q, mul_a, sh_q[KD-1 -: D]);
          sh_d  = sh_q << D;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(K)) begin
            cnt_d = '0;
            if (state_q == S_MUL) begin
              zo_d    = acc_d;
              state_d = S_SQ2;
            end else begin
              t_d     = acc_d;
              state_d = S_ADD;
            end
          end
        end
      end
      S_SQ2: begin
        a_d     = gf_sq(a_q);
        t_d     = gf_sq(t_q);
        cnt_d   = '0;
`ifdef ARS_BCOEF_EN
        state_d = S_MULB;
`else
        state_d = S_ADD;
`endif
      end
      S_ADD: begin
        xo_d    = a_q ^ t_q;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      t_q     <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      xo_q    <= '0;
      zo_q    <= '0;
`ifdef ARS_BCOEF_EN
      b_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      xo_q    <= xo_d;
      zo_q    <= zo_d;
`ifdef ARS_BCOEF_EN
      b_q     <= b_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ars_pdouble_gen.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_ars_pdouble_gen                                                |
// | Brief   : Directed vector bench for ars_pdouble_gen (default M=233, D=1).   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ars_pdouble_gen;

  localparam int M = 233;
  localparam int D = 1;
  localparam int K = (M + D - 1) / D;
`ifdef ARS_BCOEF_EN
  localparam int L = 2*K + 5;
`else
  localparam int L = K + 4;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [M-1:0] x_in = '0;
  logic [M-1:0] z_in = '0;
  logic [M-1:0] b_in = '0;
  logic         busy, done;
  logic [M-1:0] x_out, z_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ars_pdouble_gen #(.M(M), .D(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x_in  (x_in),
    .z_in  (z_in),
`ifdef ARS_BCOEF_EN
    .b_in  (b_in),
`endif
    .busy  (busy),
    .done  (done),
    .x_out (x_out),
    .z_out (z_out)
  );

  typedef struct {
    logic [M-1:0] x;
    logic [M-1:0] z;
    logic [M-1:0] b;
    logic [M-1:0] ex;
    logic [M-1:0] ez;
    bit           spur;
  } vec_t;

  function automatic logic [M-1:0] xp(input int n);
    logic [M-1:0] r;
    r = '0;
    r[n] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input int id, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h expected %h", nm, id, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int id);
    int  n;
    bit  seen;
    x_in  = v.x;
    z_in  = v.z;
    b_in  = v.b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x_in  = ~v.x;
    z_in  = ~v.z;
    b_in  = ~v.b;
    chk("busy_after_accept", id, M'(busy), M'(1));
    n    = 0;
    seen = 1'b0;
    while (!seen && n < L + 20) begin
      if (v.spur && n == 10) start = 1'b1;
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    chk("done_seen", id, M'(seen), M'(1));
    chk("latency", id, M'(n), M'(L));
    chk("x_out", id, x_out, v.ex);
    chk("z_out", id, z_out, v.ez);
    @(posedge clk); #1;
    chk("done_single_pulse", id, M'(done), M'(0));
    chk("busy_after_done", id, M'(busy), M'(0));
    chk("x_out_hold", id, x_out, v.ex);
    chk("z_out_hold", id, z_out, v.ez);
  endtask

  vec_t vecs[$];
  vec_t v;
  int   late_done;

  initial begin
    v = '{x: M'(1), z: M'(1), b: M'(1), ex: M'(0), ez: M'(1), spur: 1'b0};
    vecs.push_back(v);
    v = '{x: M'(2), z: M'(1), b: M'(1), ex: M'(17), ez: M'(4), spur: 1'b0};
    vecs.push_back(v);
    v = '{x: M'(1), z: xp(117), b: M'(1), ex: xp(150) | xp(2) | xp(0), ez: xp(75) | xp(1), spur: 1'b0};
    vecs.push_back(v);
    v = '{x: M'(1), z: M'(0), b: M'(1), ex: M'(1), ez: M'(0), spur: 1'b1};
    vecs.push_back(v);
    v = '{x: M'(0), z: M'(1), b: M'(1), ex: M'(1), ez: M'(0), spur: 1'b0};
    vecs.push_back(v);
    v = '{x: M'(4), z: M'(2), b: M'(1), ex: M'(272), ez: M'(64), spur: 1'b0};
    vecs.push_back(v);
    v = '{x: xp(60), z: M'(2), b: M'(1), ex: xp(81) | xp(7) | xp(4), ez: xp(122), spur: 1'b0};
    vecs.push_back(v);
`ifdef ARS_BCOEF_EN
    v = '{x: M'(1), z: M'(1), b: M'(2), ex: M'(3), ez: M'(1), spur: 1'b0};
    vecs.push_back(v);
`endif
    // Multiplier reduction: x^200 * x^40 = x^240; X^4 = x^400 folds twice.
    v = '{x: xp(100), z: xp(20), b: M'(1), ex: xp(167) | xp(82) | xp(80) | xp(8), ez: xp(81) | xp(7), spur: 1'b0};
    vecs.push_back(v);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", -1, M'(busy), M'(0));
    chk("reset_done", -1, M'(done), M'(0));
    chk("reset_x_out", -1, x_out, M'(0));
    chk("reset_z_out", -1, z_out, M'(0));
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i], i);

    // Abort mid-operation.
    x_in  = M'(1);
    z_in  = M'(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", -2, M'(busy), M'(0));
    chk("abort_done", -2, M'(done), M'(0));
    chk("abort_x_out", -2, x_out, M'(0));
    chk("abort_z_out", -2, z_out, M'(0));
    rst = 1'b0;
    late_done = 0;
    for (int c = 0; c < L + 5; c++) begin
      @(posedge clk); #1;
      if (done) late_done++;
    end
    chk("no_done_after_abort", -2, M'(late_done), M'(0));

    // Start in the very first cycle after reset release.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(vecs[1], 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ars_pdouble_gen.md
ARS_PDOUBLE_GEN -- requirements
Module: ars_pdouble_gen

Interface
REQ-001 SHALL have parameter M, default 233: field degree, GF(2^M) element width.
REQ-002 SHALL have parameter POLY, default M-bit value with bits 74 and 0 set: reduction polynomial x^M + POLY(x).
REQ-003 SHALL have parameter D, default 1: multiplier digit size, bits per cycle, 1 <= D <= M.
REQ-004 SHALL have port clk, input, 1: rising-edge clock; single clock domain.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request a doubling; sampled only in IDLE.
REQ-007 SHALL have port x_in, input, M: projective X1.
REQ-008 SHALL have port z_in, input, M: projective Z1.
REQ-009 SHALL have port b_in, input, M: curve coefficient b; present only when ARS_BCOEF_EN is defined.
REQ-010 SHALL have port busy, output, 1: high from the cycle after start is accepted until done.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when results are valid.
REQ-012 SHALL have port x_out, output, M: X2 = X1^4 + b*Z1^4.
REQ-013 SHALL have port z_out, output, M: Z2 = X1^2*Z1^2.

Function
REQ-014 All arithmetic SHALL be in GF(2^M) mod x^M + POLY: addition is XOR; squaring is combinational and fully reduced; multiplication is an internal digit-serial MSB-first multiplier taking K = ceil(M/D) cycles.
REQ-015 FSM states SHALL be: IDLE, SQ1 (A<=X1^2, T<=Z1^2), MUL (z_out<=A*T, K cycles), SQ2 (A<=A^2, T<=T^2), MULB (T<=b*T, K cycles, macro only), ADD (x_out<=A^T), DONE.
REQ-016 On start=1 in IDLE, x_in, z_in and b_in SHALL be latched at that edge; later input changes SHALL NOT affect the result.
REQ-017 done SHALL assert exactly L edges after the accepting edge, with L = K+4 without the macro and L = 2K+5 with it.
REQ-018 DONE SHALL last one cycle and then return to IDLE; done SHALL be high only in DONE.
REQ-019 start SHALL be ignored while busy=1 or done=1; back-to-back operation requires start in a cycle following done.
REQ-020 x_out and z_out SHALL hold their values from DONE until the next accepted start; intermediate values on them before done SHALL be treated as don't-care.
REQ-021 Degenerate inputs SHALL get no special handling: Z1=0 gives Z2=0, X2=X1^4; X1=0 gives Z2=0, X2=b*Z1^4.

Reset
REQ-022 While rst=1 at an edge, the block SHALL enter IDLE and clear busy, done, x_out, z_out and all internal registers to 0.
REQ-023 rst SHALL take priority over start.
REQ-024 rst mid-operation SHALL abort the operation with no done pulse.
REQ-025 A start in the first cycle after rst deasserts SHALL be accepted.

Configuration
REQ-026 With macro ARS_BCOEF_EN defined, the block SHALL expose b_in, execute the MULB state, and compute X2 = X1^4 + b*Z1^4.
REQ-027 With ARS_BCOEF_EN undefined, the block SHALL have no b_in port, b SHALL be fixed at 1 (Koblitz), MULB SHALL be skipped, and X2 = X1^4 + Z1^4.

Verification
REQ-028 Default parameters, no macro, x_in=1, z_in=1, start pulse: done at edge 237 (K=233), x_out=0, z_out=1.
REQ-029 No macro, x_in=2 (x), z_in=1: x_out=0x11 (x^4+1), z_out=0x4 (x^2).
REQ-030 No macro, reduction check: x_in=1, z_in=x^117: z_out = x^75 + x, x_out = x^150 + x^2 + 1.
REQ-031 No macro, x_in=1, z_in=0: x_out=1, z_out=0; additionally, a start pulse 10 cycles into a run is ignored (single done, unchanged latency).
REQ-032 No macro, rst asserted 50 cycles after start: next edge busy=0, done=0, x_out=0, z_out=0, no done follows; fresh start then completes normally.
REQ-033 ARS_BCOEF_EN, b_in=2, x_in=1, z_in=1: done at edge 471, x_out=0x3, z_out=1; repeat with D=8 (K=30): done at edge 65, same results.
